// File: rtl/pll_reconfig_sequencer.sv
// Reconfiguration sequencer for the SDRAM-clock PLL.
// Walks the frequency write list over the Avalon-MM reconfig port with
// waitrequest handshaking, pulses the PLL reset, waits for lock (with a
// timeout) and finally applies a relative C1 phase step to reach the
// requested absolute phase. Reports completion with done/err.
module pll_reconfig_sequencer #(
    parameter int BASE_PHASE   = 29,
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 500000
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        req,
    input  logic [31:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [31:0] cfg_c,
    input  logic [7:0]  cfg_phase,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  cur_phase,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    output logic        pll_reset,
    input  logic        locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_PRST,
        S_LOCKWAIT,
        S_DONE
    } state_t;

    // Write list indices: 0..8 are the frequency writes, 9..11 the phase step.
    localparam logic [3:0]  LAST_FREQ   = 4'd8;
    localparam logic [3:0]  FIRST_PHASE = 4'd9;
    localparam logic [3:0]  LAST_PHASE  = 4'd11;

    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [8:0]  BASE9     = 9'(BASE_PHASE);
    localparam logic [7:0]  BASE8     = 8'(BASE_PHASE);

    state_t      r_state;
    state_t      w_nextState;

    logic [3:0]  r_idx;
    logic [31:0] r_cnt;
    logic [31:0] r_cfgM;
    logic [31:0] r_cfgK;
    logic [31:0] r_cfgC;
    logic [7:0]  r_cfgPhase;
    logic        r_err;
    logic [7:0]  r_curPhase;
    logic        r_lockMeta;
    logic        r_lockSync;
    logic        r_lockPrev;

    logic [8:0]  w_delta;
    logic [7:0]  w_absDelta;
    logic [31:0] w_phaseWord;
    logic [5:0]  w_tblAddr;
    logic [31:0] w_tblData;
    logic        w_lockOk;
    logic        w_timeout;
    logic        w_advance;
    logic        w_accept;
    logic        w_writeDone;

    // Signed phase step from the compiled phase to the requested phase, and the
    // phase-shift register word: magnitude, counter select C1, direction bit.
    always_comb begin
        w_delta     = {1'b0, r_cfgPhase} - BASE9;
        w_absDelta  = w_delta[8] ? 8'(9'd0 - w_delta) : w_delta[7:0];
        w_phaseWord = {10'd0, w_delta[8], 4'd0, 1'b1, 8'd0, w_absDelta};
    end

    // Address/data lookup for the current entry of the combined write list.
    always_comb begin
        w_tblAddr = 6'd0;
        w_tblData = 32'd0;
        case (r_idx)
            4'd0:    begin w_tblAddr = 6'd0; w_tblData = 32'd0;                     end
            4'd1:    begin w_tblAddr = 6'd4; w_tblData = r_cfgM;                    end
            4'd2:    begin w_tblAddr = 6'd7; w_tblData = r_cfgK;                    end
            4'd3:    begin w_tblAddr = 6'd3; w_tblData = 32'h0001_0000;             end
            4'd4:    begin w_tblAddr = 6'd5; w_tblData = r_cfgC;                    end
            4'd5:    begin w_tblAddr = 6'd5; w_tblData = r_cfgC | 32'h0004_0000;    end
            4'd6:    begin w_tblAddr = 6'd9; w_tblData = 32'd1;                     end
            4'd7:    begin w_tblAddr = 6'd8; w_tblData = 32'd7;                     end
            4'd8:    begin w_tblAddr = 6'd2; w_tblData = 32'd0;                     end
            4'd9:    begin w_tblAddr = 6'd0; w_tblData = 32'd0;                     end
            4'd10:   begin w_tblAddr = 6'd6; w_tblData = w_phaseWord;               end
            4'd11:   begin w_tblAddr = 6'd2; w_tblData = 32'd0;                     end
            default: begin w_tblAddr = 6'd0; w_tblData = 32'd0;                     end
        endcase
    end

    // Next-state logic and Moore outputs; lock success takes priority over timeout.
    always_comb begin
        w_nextState    = r_state;
        w_lockOk       = 1'b0;
        w_timeout      = 1'b0;
        w_advance      = 1'b0;
        w_accept       = 1'b0;
        w_writeDone    = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        pll_reset      = 1'b0;
        busy           = (r_state != S_IDLE);
        done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = w_tblAddr;
                mgmt_writedata = w_tblData;
                if (!mgmt_waitrequest) begin
                    w_writeDone = 1'b1;
                    w_nextState = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    if (r_idx == LAST_FREQ) begin
                        w_nextState = S_PRST;
                    end else if (r_idx == LAST_PHASE) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_nextState = S_WRITE;
                    end
                end
            end
            S_PRST: begin
                pll_reset = 1'b1;
                if (r_cnt == RST_LAST) begin
                    w_nextState = S_LOCKWAIT;
                end
            end
            S_LOCKWAIT: begin
                if (r_lockSync && r_lockPrev) begin
                    w_lockOk    = 1'b1;
                    w_nextState = (w_delta == 9'd0) ? S_DONE : S_WRITE;
                end else if (r_cnt == LOCK_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State register; RESET aborts any sequence immediately.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath: latched request, list index, shared cycle counter, lock sync, status.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_idx      <= 4'd0;
            r_cnt      <= 32'd0;
            r_cfgM     <= 32'd0;
            r_cfgK     <= 32'd0;
            r_cfgC     <= 32'd0;
            r_cfgPhase <= BASE8;
            r_err      <= 1'b0;
            r_curPhase <= BASE8;
            r_lockMeta <= 1'b0;
            r_lockSync <= 1'b0;
            r_lockPrev <= 1'b0;
        end else begin
            r_lockMeta <= locked;
            r_lockSync <= r_lockMeta;
            r_lockPrev <= (r_state == S_LOCKWAIT) && r_lockSync;

            if (r_state != w_nextState) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_accept) begin
                r_cfgM     <= cfg_m;
                r_cfgK     <= cfg_k;
                r_cfgC     <= cfg_c;
                r_cfgPhase <= cfg_phase;
                r_err      <= 1'b0;
                r_idx      <= 4'd0;
            end

            if (w_advance) begin
                r_idx <= r_idx + 4'd1;
            end

            if (r_state == S_PRST) begin
                r_curPhase <= BASE8;
            end

            if (w_lockOk) begin
                r_idx <= FIRST_PHASE;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_writeDone && (r_idx == LAST_PHASE)) begin
                r_curPhase <= r_cfgPhase;
            end
        end
    end

    assign err       = r_err;
    assign cur_phase = r_curPhase;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard testbench for pll_reconfig_sequencer: stimulus pushes the
// expected reconfig writes and completion reports, a monitor pops and
// compares them as the DUT presents writes and done pulses.
module tb_pll_reconfig_sequencer;

    localparam int BASE = 29;
    localparam int GAP  = 7;
    localparam int RSTC = 8;
    localparam int LT   = 200;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          hold;
    } wr_t;

    typedef struct {
        logic        err;
        logic [7:0]  phase;
        bit          chkErrAt;
    } dn_t;

    logic        CLK_50M = 1'b0;
    logic        RESET = 1'b1;
    logic        req = 1'b0;
    logic [31:0] cfg_m = '0;
    logic [31:0] cfg_k = '0;
    logic [31:0] cfg_c = '0;
    logic [7:0]  cfg_phase = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  cur_phase;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest;
    logic        pll_reset;
    logic        locked = 1'b0;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    wr_t expWrites[$];
    dn_t expDone[$];

    int  stallArm = 0;
    int  stallUsed = 0;
    bit  lockEn = 1'b1;
    int  lockCnt = 0;
    bit  lockArmed = 1'b0;

    int  holdCnt = 0;
    bit  inGap = 1'b0;
    int  gapCnt = 0;
    int  rstRun = 0;
    bit  prevRst = 1'b0;
    bit  prevErr = 1'b0;
    int  sinceFall = 0;
    int  errRiseAt = -1;
    bit  doneFollow = 1'b0;
    wr_t curWr;
    dn_t curDn;

    pll_reconfig_sequencer #(
        .BASE_PHASE  (BASE),
        .GAP_CYCLES  (GAP),
        .RST_CYCLES  (RSTC),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .CLK_50M         (CLK_50M),
        .RESET           (RESET),
        .req             (req),
        .cfg_m           (cfg_m),
        .cfg_k           (cfg_k),
        .cfg_c           (cfg_c),
        .cfg_phase       (cfg_phase),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .cur_phase       (cur_phase),
        .mgmt_address    (mgmt_address),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_write      (mgmt_write),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_reset       (pll_reset),
        .locked          (locked)
    );

    // 50 MHz clock
    always #10 CLK_50M = ~CLK_50M;

    // Reconfig slave model: stalls the M-counter write for stallArm cycles
    assign mgmt_waitrequest = mgmt_write && (mgmt_address == 6'd4) && (stallUsed < stallArm);

    always @(posedge CLK_50M) begin
        if (!(mgmt_write && (mgmt_address == 6'd4))) stallUsed <= 0;
        else if (mgmt_waitrequest) stallUsed <= stallUsed + 1;
    end

    // PLL model: loses lock in reset, relocks 20 cycles after reset is released
    always @(posedge CLK_50M) begin
        if (RESET) begin
            locked    <= 1'b0;
            lockArmed <= 1'b0;
            lockCnt   <= 0;
        end else if (pll_reset) begin
            locked    <= 1'b0;
            lockArmed <= 1'b1;
            lockCnt   <= 0;
        end else if (lockArmed) begin
            if (lockEn && lockCnt == 19) begin
                locked    <= 1'b1;
                lockArmed <= 1'b0;
            end else begin
                lockCnt <= lockCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares every presented write, gap, reset pulse and done report
    always @(negedge CLK_50M) begin
        if (RESET) begin
            holdCnt    = 0;
            inGap      = 1'b0;
            rstRun     = 0;
            prevRst    = 1'b0;
            doneFollow = 1'b0;
        end else begin
            if (pll_reset) begin
                rstRun++;
                sinceFall++;
            end else if (prevRst) begin
                checkOutput("pll_reset width", rstRun, RSTC);
                rstRun    = 0;
                sinceFall = 0;
                errRiseAt = -1;
            end else begin
                sinceFall++;
            end
            prevRst = pll_reset;
            if (err && !prevErr) errRiseAt = sinceFall;
            prevErr = err;

            if (pll_reset || !busy) inGap = 1'b0;

            if (mgmt_write) begin
                holdCnt++;
                if (inGap) begin
                    checkOutput("gap length", gapCnt, GAP);
                    inGap = 1'b0;
                end
                checkOutput("write expected", expWrites.size() != 0, 1);
                if (expWrites.size() != 0) begin
                    curWr = expWrites[0];
                    checkOutput("write address", mgmt_address, curWr.addr);
                    checkOutput("write data", mgmt_writedata, curWr.data);
                    if (!mgmt_waitrequest) begin
                        checkOutput("write hold cycles", holdCnt, curWr.hold);
                        void'(expWrites.pop_front());
                    end
                end
                if (!mgmt_waitrequest) begin
                    holdCnt = 0;
                    inGap   = 1'b1;
                    gapCnt  = 0;
                end
            end else if (inGap) begin
                gapCnt++;
            end

            if (doneFollow) begin
                checkOutput("busy after done", busy, 0);
                checkOutput("done width", done, 0);
                doneFollow = 1'b0;
            end else if (done) begin
                checkOutput("busy during done", busy, 1);
                checkOutput("done expected", expDone.size() != 0, 1);
                checkOutput("writes outstanding at done", expWrites.size(), 0);
                if (expDone.size() != 0) begin
                    curDn = expDone.pop_front();
                    checkOutput("err at done", err, curDn.err);
                    checkOutput("cur_phase at done", cur_phase, curDn.phase);
                    if (curDn.chkErrAt) checkOutput("err rise cycle", 64'(errRiseAt), LT);
                end
                doneFollow = 1'b1;
                doneCount++;
            end
        end
    end

    task automatic pushExpected(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                                input logic [7:0] ph, input logic [31:0] phaseWord,
                                input int stall, input bit lockOk);
        wr_t w;
        dn_t d;
        logic [5:0]  addrs[9] = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd5, 6'd9, 6'd8, 6'd2};
        logic [31:0] datas[9];
        datas = '{32'd0, m, k, 32'h0001_0000, c, c | 32'h0004_0000, 32'd1, 32'd7, 32'd0};
        for (int i = 0; i < 9; i++) begin
            w.addr = addrs[i];
            w.data = datas[i];
            w.hold = (i == 1) ? stall + 1 : 1;
            expWrites.push_back(w);
        end
        if (lockOk && phaseWord != 32'd0) begin
            w.hold = 1;
            w.addr = 6'd0; w.data = 32'd0;      expWrites.push_back(w);
            w.addr = 6'd6; w.data = phaseWord;  expWrites.push_back(w);
            w.addr = 6'd2; w.data = 32'd0;      expWrites.push_back(w);
        end
        d.err      = !lockOk;
        d.phase    = (lockOk && phaseWord != 32'd0) ? ph : 8'(BASE);
        d.chkErrAt = !lockOk;
        expDone.push_back(d);
    endtask

    task automatic issueReq(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                            input logic [7:0] ph);
        @(negedge CLK_50M);
        cfg_m     = m;
        cfg_k     = k;
        cfg_c     = c;
        cfg_phase = ph;
        req       = 1'b1;
        @(negedge CLK_50M);
        req = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int start;
        bit seen;
        start = doneCount;
        seen  = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CLK_50M);
            if (doneCount != start) seen = 1'b1;
        end
        checkOutput(name, seen, 1);
        repeat (3) @(negedge CLK_50M);
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] m, input logic [31:0] k,
                                 input logic [31:0] c, input logic [7:0] ph,
                                 input logic [31:0] phaseWord, input int stall, input bit lockOk);
        $display("[TB] %s", name);
        stallArm = stall;
        lockEn   = lockOk;
        pushExpected(m, k, c, ph, phaseWord, stall, lockOk);
        issueReq(m, k, c, ph);
        waitDone({name, " done"});
        stallArm = 0;
        lockEn   = 1'b1;
    endtask

    initial begin
        bit seenK;
        RESET = 1'b1;
        repeat (3) @(negedge CLK_50M);
        checkOutput("reset mgmt_write", mgmt_write, 0);
        checkOutput("reset mgmt_address", mgmt_address, 0);
        checkOutput("reset mgmt_writedata", mgmt_writedata, 0);
        checkOutput("reset pll_reset", pll_reset, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset cur_phase", cur_phase, BASE);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_50M);

        applyStimulus("test1 phase 29", 32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd29, 32'h0, 0, 1'b1);
        applyStimulus("test2 phase 31", 32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd31, 32'h0001_0002, 0, 1'b1);
        applyStimulus("test3 phase 14", 32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd14, 32'h0021_000F, 0, 1'b1);
        applyStimulus("test4 M stall", 32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd29, 32'h0, 5, 1'b1);
        applyStimulus("test5 lock timeout", 32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd31, 32'h0001_0002, 0, 1'b0);

        $display("[TB] test6 reset during K write");
        pushExpected(32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd29, 32'h0, 0, 1'b1);
        issueReq(32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd29);
        checkOutput("err cleared on accept", err, 0);
        seenK = 1'b0;
        for (int i = 0; i < 200 && !seenK; i++) begin
            @(negedge CLK_50M);
            if (mgmt_write && mgmt_address == 6'd7) seenK = 1'b1;
        end
        checkOutput("K write reached", seenK, 1);
        #1 RESET = 1'b1;
        @(negedge CLK_50M);
        checkOutput("abort mgmt_write", mgmt_write, 0);
        checkOutput("abort busy", busy, 0);
        expWrites.delete();
        expDone.delete();
        @(negedge CLK_50M);
        checkOutput("abort cur_phase", cur_phase, BASE);
        #1 RESET = 1'b0;
        repeat (2) @(negedge CLK_50M);

        pushExpected(32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd31, 32'h0001_0002, 0, 1'b1);
        issueReq(32'h0000_0808, 32'hB333_32DD, 32'h0002_0302, 8'd31);
        repeat (30) @(negedge CLK_50M);
        issueReq(32'h0001_2345, 32'h1111_1111, 32'h0000_0101, 8'd40);
        waitDone("test6 restart done");
        repeat (20) @(negedge CLK_50M);
        checkOutput("idle after ignored req", busy, 0);
        checkOutput("no writes left", expWrites.size(), 0);
        checkOutput("final cur_phase", cur_phase, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
